// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the IF/LS memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_t;

    localparam logic       WE_READ   = 1'b0;
    localparam logic       WE_WRITE  = 1'b1;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection between IF and LS requests
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic i_if_req,
    input  logic i_ls_req,
    input  gnt_t i_last_grant,
    output gnt_t o_gnt
);

    always_comb begin
        o_gnt = GNT_IF;
        if (i_ls_req && !i_if_req) begin
            o_gnt = GNT_LS;
        end else if (i_ls_req && i_if_req) begin
            // Round-robin hands contention to whichever port was not served last
            if (DATA_PRIORITY != 0) begin
                o_gnt = GNT_LS;
            end else begin
                o_gnt = (i_last_grant == GNT_IF) ? GNT_LS : GNT_IF;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IF and LS accesses onto one single-port memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int DATA_PRIORITY = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we_re,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_mask,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_w_data,
    output logic [3:0]        mem_masking,
    output logic              mem_we_re,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next_state;
    gnt_t              r_gnt;
    gnt_t              r_last_grant;
    gnt_t              w_win;
    logic [WD_W-1:0]   r_wd;
    logic              r_mem_request;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_w_data;
    logic [3:0]        r_mem_masking;
    logic              r_mem_we_re;
    logic              w_any_req;
    logic              w_expired;

    assign w_any_req = if_req | ls_req;
    // Fires in the TIMEOUT-th BUSY cycle, so err pulses while still BUSY
    assign w_expired = (r_wd == WD_W'(TIMEOUT - 1));

    arb_pick #(
        .DATA_PRIORITY (DATA_PRIORITY)
    ) u_arb_pick (
        .i_if_req     (if_req),
        .i_ls_req     (ls_req),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_win)
    );

    always_comb begin
        w_next_state = r_state;
        if_valid     = 1'b0;
        ls_valid     = 1'b0;
        if_err       = 1'b0;
        ls_err       = 1'b0;
        if_rdata     = '0;
        ls_rdata     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_valid) begin
                    w_next_state = ST_IDLE;
                    if (r_gnt == GNT_IF) begin
                        if_valid = 1'b1;
                        if_rdata = mem_r_data;
                    end else begin
                        ls_valid = 1'b1;
                        ls_rdata = mem_r_data;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_IDLE;
                    if (r_gnt == GNT_IF) begin
                        if_err = 1'b1;
                    end else begin
                        ls_err = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_gnt         <= GNT_IF;
            r_last_grant  <= GNT_IF;
            r_wd          <= '0;
            r_mem_request <= 1'b0;
            r_mem_address <= '0;
            r_mem_w_data  <= '0;
            r_mem_masking <= '0;
            r_mem_we_re   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_mem_request <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_wd <= '0;
                if (w_any_req) begin
                    r_gnt         <= w_win;
                    r_mem_request <= 1'b1;
                    if (w_win == GNT_LS) begin
                        r_mem_address <= ls_addr;
                        r_mem_w_data  <= ls_wdata;
                        r_mem_masking <= ls_mask;
                        r_mem_we_re   <= ls_we_re;
                    end else begin
                        r_mem_address <= if_addr;
                        r_mem_w_data  <= '0;
                        r_mem_masking <= MASK_WORD;
                        r_mem_we_re   <= WE_READ;
                    end
                end
            end else if (w_next_state == ST_IDLE) begin
                r_last_grant <= r_gnt;
                r_wd         <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign mem_request = r_mem_request;
    assign mem_address = r_mem_address;
    assign mem_w_data  = r_mem_w_data;
    assign mem_masking = r_mem_masking;
    assign mem_we_re   = r_mem_we_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        ls_req;
    logic        ls_we_re;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_mask;
    logic        mem_en;

    logic        if_valid_p1, if_err_p1, ls_valid_p1, ls_err_p1, mem_request_p1, mem_we_re_p1;
    logic [31:0] if_rdata_p1, ls_rdata_p1, mem_w_data_p1;
    logic [7:0]  mem_address_p1;
    logic [3:0]  mem_masking_p1;
    logic        mv_p1 = 1'b0;
    logic [31:0] rd_p1 = '0;

    logic        if_valid_p0, if_err_p0, ls_valid_p0, ls_err_p0, mem_request_p0, mem_we_re_p0;
    logic [31:0] if_rdata_p0, ls_rdata_p0, mem_w_data_p0;
    logic [7:0]  mem_address_p0;
    logic [3:0]  mem_masking_p0;
    logic        mv_p0 = 1'b0;
    logic [31:0] rd_p0 = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT(15)) dut_p1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid_p1), .if_rdata(if_rdata_p1), .if_err(if_err_p1),
        .ls_req(ls_req), .ls_we_re(ls_we_re), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
        .ls_valid(ls_valid_p1), .ls_rdata(ls_rdata_p1), .ls_err(ls_err_p1),
        .mem_request(mem_request_p1), .mem_address(mem_address_p1), .mem_w_data(mem_w_data_p1),
        .mem_masking(mem_masking_p1), .mem_we_re(mem_we_re_p1), .mem_valid(mv_p1), .mem_r_data(rd_p1)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT(15)) dut_p0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid_p0), .if_rdata(if_rdata_p0), .if_err(if_err_p0),
        .ls_req(ls_req), .ls_we_re(ls_we_re), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
        .ls_valid(ls_valid_p0), .ls_rdata(ls_rdata_p0), .ls_err(ls_err_p0),
        .mem_request(mem_request_p0), .mem_address(mem_address_p0), .mem_w_data(mem_w_data_p0),
        .mem_masking(mem_masking_p0), .mem_we_re(mem_we_re_p0), .mem_valid(mv_p0), .mem_r_data(rd_p0)
    );

    function automatic logic [31:0] mdata(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'h5A5A5A, a};
    endfunction

    // Memory model: completes one cycle after each request unless disabled
    always @(posedge clk) begin
        mv_p1 <= mem_request_p1 && mem_en;
        rd_p1 <= mdata(mem_address_p1);
        mv_p0 <= mem_request_p0 && mem_en;
        rd_p0 <= mdata(mem_address_p0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we_re = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_mask = '0; mem_en = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_mem_request", mem_request_p1, 0);
        chk("rst_mem_address", mem_address_p1, 0);
        chk("rst_mem_masking", mem_masking_p1, 0);
        chk("rst_if_valid", if_valid_p1, 0);
        chk("rst_ls_valid", ls_valid_p1, 0);
        chk("rst_if_rdata", if_rdata_p1, 0);

        // IF-only read
        if_req = 1'b1; if_addr = 8'h10;
        step();
        chk("if_rd_req", mem_request_p1, 1);
        chk("if_rd_addr", mem_address_p1, 8'h10);
        chk("if_rd_we", mem_we_re_p1, 0);
        chk("if_rd_mask", mem_masking_p1, 4'hF);
        chk("if_rd_early_valid", if_valid_p1, 0);
        step();
        chk("if_rd_valid", if_valid_p1, 1);
        chk("if_rd_data", if_rdata_p1, 32'hDEADBEEF);
        chk("if_rd_ls_valid", ls_valid_p1, 0);
        chk("if_rd_req_once", mem_request_p1, 0);
        if_req = 1'b0;
        step();
        chk("if_rd_after_valid", if_valid_p1, 0);
        chk("if_rd_after_rdata", if_rdata_p1, 0);

        // LS write
        ls_req = 1'b1; ls_we_re = 1'b1; ls_addr = 8'h20; ls_wdata = 32'h12345678; ls_mask = 4'b0011;
        step();
        chk("ls_wr_req", mem_request_p1, 1);
        chk("ls_wr_addr", mem_address_p1, 8'h20);
        chk("ls_wr_wdata", mem_w_data_p1, 32'h12345678);
        chk("ls_wr_mask", mem_masking_p1, 4'b0011);
        chk("ls_wr_we", mem_we_re_p1, 1);
        step();
        chk("ls_wr_req_once", mem_request_p1, 0);
        chk("ls_wr_addr_hold", mem_address_p1, 8'h20);
        chk("ls_wr_wdata_hold", mem_w_data_p1, 32'h12345678);
        chk("ls_wr_valid", ls_valid_p1, 1);
        chk("ls_wr_if_valid", if_valid_p1, 0);
        ls_req = 1'b0;
        step();
        chk("ls_wr_after_valid", ls_valid_p1, 0);

        // Contention with LS priority
        ls_req = 1'b1; ls_we_re = 1'b0; ls_addr = 8'h30; if_req = 1'b1; if_addr = 8'h40;
        for (int t = 0; t < 4; t++) begin
            if (t != 0) step();
            step(); step();
            chk($sformatf("prio_ls_valid_%0d", t), ls_valid_p1, 1);
            chk($sformatf("prio_if_valid_%0d", t), if_valid_p1, 0);
            chk($sformatf("prio_ls_rdata_%0d", t), ls_rdata_p1, 32'h5A5A5A30);
        end
        ls_req = 1'b0;
        step(); step();
        chk("prio_if_addr", mem_address_p1, 8'h40);
        step();
        chk("prio_if_valid", if_valid_p1, 1);
        chk("prio_if_rdata", if_rdata_p1, 32'h5A5A5A40);
        if_req = 1'b0;
        step();

        // Contention, round-robin instance
        rst = 1'b1;
        step();
        rst = 1'b0; ls_req = 1'b1; if_req = 1'b1;
        step(); step();
        chk("rr_0_ls", ls_valid_p0, 1);
        chk("rr_0_if", if_valid_p0, 0);
        step();
        chk("rr_gap_ls", ls_valid_p0, 0);
        chk("rr_gap_if", if_valid_p0, 0);
        step(); step();
        chk("rr_1_if", if_valid_p0, 1);
        chk("rr_1_ls", ls_valid_p0, 0);
        step(); step(); step();
        chk("rr_2_ls", ls_valid_p0, 1);
        chk("rr_2_if", if_valid_p0, 0);
        step(); step(); step();
        chk("rr_3_if", if_valid_p0, 1);
        chk("rr_3_ls", ls_valid_p0, 0);
        ls_req = 1'b0; if_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Watchdog timeout
        mem_en = 1'b0; if_req = 1'b1; if_addr = 8'h50;
        for (int c = 1; c < 15; c++) begin
            step();
            chk($sformatf("to_no_err_%0d", c), if_err_p1, 0);
        end
        step();
        chk("to_if_err", if_err_p1, 1);
        chk("to_if_valid", if_valid_p1, 0);
        chk("to_ls_err", ls_err_p1, 0);
        if_req = 1'b0; mem_en = 1'b1;
        step();
        chk("to_err_once", if_err_p1, 0);
        chk("to_idle_req", mem_request_p1, 0);
        ls_req = 1'b1; ls_we_re = 1'b0; ls_addr = 8'h60;
        step();
        chk("to_ls_req", mem_request_p1, 1);
        chk("to_ls_addr", mem_address_p1, 8'h60);
        step();
        chk("to_ls_valid", ls_valid_p1, 1);
        chk("to_ls_rdata", ls_rdata_p1, 32'h5A5A5A60);
        ls_req = 1'b0;
        step();

        // Reset mid-transaction, then stray mem_valid
        if_req = 1'b1; if_addr = 8'h70;
        step();
        chk("rm_req", mem_request_p1, 1);
        rst = 1'b1; if_req = 1'b0;
        step();
        rst = 1'b0;
        chk("rm_stray_mv", mv_p1, 1);
        chk("rm_if_valid", if_valid_p1, 0);
        chk("rm_if_err", if_err_p1, 0);
        chk("rm_if_rdata", if_rdata_p1, 0);
        chk("rm_mem_request", mem_request_p1, 0);
        chk("rm_mem_address", mem_address_p1, 0);
        ls_req = 1'b1; ls_addr = 8'h80;
        step();
        chk("rm_next_req", mem_request_p1, 1);
        chk("rm_next_addr", mem_address_p1, 8'h80);
        step();
        chk("rm_next_valid", ls_valid_p1, 1);
        chk("rm_next_rdata", ls_rdata_p1, 32'h5A5A5A80);
        ls_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch (IF) port and the load/store (LS) port of the core.
- Memory side uses a request/valid handshake: `valid` returns one cycle after `request`.
- Serialises transactions, holds address/data stable for the whole transaction, and routes `r_data`/`valid` back to the granted requester.
- Includes a watchdog that aborts a transaction whose memory response never arrives.

Parameters:
- ADDR_W, 8, memory word address width
- DATA_W, 32, data width
- DATA_PRIORITY, 1, 1 = LS always wins contention; 0 = round-robin
- TIMEOUT, 15, BUSY cycles without `mem_valid` before abort (must be at least 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  IF read request, held until `if_valid` or `if_err`
- if_addr  in  ADDR_W  IF address
- if_valid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  DATA_W  IF read data
- if_err  out  1  one-cycle pulse: IF transaction timed out
- ls_req  in  1  LS request, held until `ls_valid` or `ls_err`
- ls_we_re  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  DATA_W  LS write data
- ls_mask  in  4  LS byte-enable mask
- ls_valid  out  1  one-cycle pulse: LS done (`ls_rdata` valid on reads)
- ls_rdata  out  DATA_W  LS read data
- ls_err  out  1  one-cycle pulse: LS transaction timed out
- mem_request  out  1  one-cycle request pulse to memory
- mem_address  out  ADDR_W  registered address
- mem_w_data  out  DATA_W  registered write data
- mem_masking  out  4  registered mask
- mem_we_re  out  1  registered write enable (1 = write)
- mem_valid  in  1  memory completion
- mem_r_data  in  DATA_W  memory read data

Behaviour:
- **Reset.** `rst` high at a clock edge forces:
  - state = IDLE, `last_grant` = IF, watchdog = 0;
  - all `mem_*` outputs = 0; all valid/err outputs = 0; rdata outputs = 0.
  - Reset mid-transaction drops the transaction silently. A `mem_valid` arriving after reset is ignored.
- **FSM states:** IDLE, BUSY.
- **IDLE, no request.** Stay in IDLE, `mem_request` = 0.
- **IDLE, at least one request.** Select a grant:
  - Only one port requesting: that port wins.
  - Both requesting, DATA_PRIORITY = 1: LS wins.
  - Both requesting, DATA_PRIORITY = 0: the port not equal to `last_grant` wins.
- **Registered grant actions (on the edge that leaves IDLE):**
  - register grant into `gnt`;
  - latch the winner's address, wdata, mask and `we_re` into `mem_*` (IF port: `we_re` = 0, mask = 4'b1111, wdata = 0);
  - set `mem_request` = 1; go to BUSY.
- **BUSY.**
  - `mem_request` = 0 from the second BUSY cycle onward; exactly one pulse per transaction.
  - `mem_*` address/data/mask/`we_re` stay stable.
  - Watchdog increments each BUSY cycle.
- **BUSY with `mem_valid` = 1.**
  - Granted port's valid = 1 (combinational); its rdata = `mem_r_data`.
  - `last_grant` <= `gnt`; go to IDLE; watchdog cleared.
  - The non-granted port's outputs stay 0.
- **Latency.**
  - Request sampled in IDLE at cycle 0 → `mem_request` at cycle 1 → port valid at cycle 2 (nominal memory).
  - The minimum back-to-back period is 3 cycles per transaction.
- **Watchdog.** If the watchdog reaches TIMEOUT in BUSY without `mem_valid`:
  - pulse the granted port's err for one cycle;
  - return to IDLE; `last_grant` <= `gnt`.
- **Held requests.**
  - A requester keeping `req` high in the cycle after valid/err starts a new transaction; it is re-arbitrated in IDLE.
  - Requests arriving while BUSY wait; they are never lost because they are held by protocol.
- **`mem_valid` while IDLE.** Ignored.
- **rdata outside a valid cycle.** rdata outputs = 0.

Decomposition:
- Package `mem_arb_pkg`:
  - state encoding (IDLE = 0, BUSY = 1);
  - grant encoding (GNT_IF = 0, GNT_LS = 1);
  - constants WE_READ = 0, WE_WRITE = 1, MASK_WORD = 4'b1111.
- One natural sub-module, `arb_pick`: combinational winner selection from `if_req`, `ls_req`, `last_grant`, DATA_PRIORITY.
- Watchdog counter and FSM stay in the top.

Test Plan:
- IF-only read: `if_req`, `if_addr` = 8'h10; memory returns 32'hDEADBEEF one cycle after request → `mem_request` at cycle 1 with `mem_address` = 8'h10, `mem_we_re` = 0, `mem_masking` = 4'hF; `if_valid` = 1 with 32'hDEADBEEF at cycle 2; `ls_valid` stays 0.
- LS write: `ls_we_re` = 1, `ls_addr` = 8'h20, `ls_wdata` = 32'h12345678, `ls_mask` = 4'b0011 → `mem_*` carry those values through BUSY; `ls_valid` pulses at cycle 2; single `mem_request` pulse.
- Contention, DATA_PRIORITY = 1: both requests held for 4 transactions → order LS, LS, LS, LS while `ls_req` stays high; IF served only after `ls_req` drops.
- Contention, DATA_PRIORITY = 0: both requests held continuously from reset → grant order LS, IF, LS, IF; each valid 3 cycles apart.
- Timeout: `if_req`, memory never asserts valid, TIMEOUT = 15 → `if_err` pulses once after 15 BUSY cycles; FSM returns to IDLE; a subsequent LS request completes normally.
- Reset mid-op: assert `rst` in the BUSY cycle, then inject `mem_valid` the next cycle → no valid/err pulses; all outputs 0; next request handled from IDLE.
